ddr3_apb_master: RTL

- APB initiator that drives the DDR3 controller register block (mode registers 0x00–0x05, arbiter registers 0xE0–0xF4).
- Takes single register commands over a valid/ready command port from the test sequencer or init engine.
- Runs a standard two-phase APB transfer (SETUP, then ACCESS) for each command.
- Returns read data or completion status over a valid/ready response port. Adds a timeout so a slave that never asserts ready cannot hang the bus.

---
 rtl/ddr3_apb_master.sv | 107 ++++++++++
 1 files changed

// File: rtl/ddr3_apb_master.sv
// APB initiator for the DDR3 controller register block: accepts one register
// command at a time, runs SETUP/ACCESS on APB and returns data/status.
module ddr3_apb_master #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 16
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic              apb_sel,
    output logic              apb_enable,
    output logic              apb_write,
    output logic [ADDR_W-1:0] apb_addr,
    output logic [DATA_W-1:0] apb_wdata,
    input  logic              apb_ready,
    input  logic [DATA_W-1:0] apb_rdata
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t             state_reg;
    logic [CNT_W-1:0]   wait_cnt_reg;
    logic               timeout_hit;

    // Abort on the edge that closes the TIMEOUT-th ACCESS cycle without PREADY.
    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt_reg == CNT_W'(TIMEOUT - 1));

    // Gated by reset so nothing is offered while the block is held in reset.
    assign cmd_ready = (state_reg == IDLE) && !areset;
    assign busy      = (state_reg != IDLE);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= '0;
            apb_sel      <= 1'b0;
            apb_enable   <= 1'b0;
            apb_write    <= 1'b0;
            apb_addr     <= '0;
            apb_wdata    <= '0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cmd_valid) begin
                        apb_write <= cmd_write;
                        apb_addr  <= cmd_addr;
                        apb_wdata <= cmd_wdata;
                        apb_sel   <= 1'b1;
                        state_reg <= SETUP;
                    end
                end
                SETUP: begin
                    wait_cnt_reg <= '0;
                    apb_enable   <= 1'b1;
                    state_reg    <= ACCESS;
                end
                ACCESS: begin
                    if (apb_ready) begin
                        rsp_rdata  <= apb_write ? '0 : apb_rdata;
                        rsp_err    <= 1'b0;
                        rsp_valid  <= 1'b1;
                        apb_sel    <= 1'b0;
                        apb_enable <= 1'b0;
                        state_reg  <= RESP;
                    end else if (timeout_hit) begin
                        rsp_rdata  <= '0;
                        rsp_err    <= 1'b1;
                        rsp_valid  <= 1'b1;
                        apb_sel    <= 1'b0;
                        apb_enable <= 1'b0;
                        state_reg  <= RESP;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
